// File: rtl/axi_rd_rr_arbiter.sv
// Three-master AXI read-channel arbiter: one burst at a time over a shared outer AR/R channel.
// Define ARB_FIXED_PRIO_EN for fixed priority m1 > m2 > m0; default build is round-robin.
module axi_rd_rr_arbiter #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  ID_BASE = 4'd0
) (
  input  logic                aclk,
  input  logic                aresetn,
  // per-master side
  input  logic [3*ADDR_W-1:0] m_araddr,
  input  logic [3*4-1:0]      m_arlen,
  input  logic [3*3-1:0]      m_arsize,
  input  logic [2:0]          m_arvalid,
  output logic [2:0]          m_arready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_rlast,
  output logic [2:0]          m_rvalid,
  input  logic [2:0]          m_rready,
  // outer AR channel
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // outer R channel
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                len_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  len_q, len_d;
  logic        len_err_q, len_err_d;

  // Only one burst is ever outstanding, so rid/rresp carry no routing information.
  logic unused_r_fields;
  assign unused_r_fields = ^{rid, rresp};

  assign arid    = ID_BASE + {2'b00, gnt_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign len_err = len_err_q;
  assign m_rdata = rdata;

  // Per-master views of the granted master's request and ready.
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_len;
  logic [2:0]        sel_size;
  logic              sel_arvalid;
  logic              sel_rready;

  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    sel_size    = '0;
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q == 2'(i)) begin
        sel_addr    = m_araddr[i*ADDR_W +: ADDR_W];
        sel_len     = m_arlen[i*4 +: 4];
        sel_size    = m_arsize[i*3 +: 3];
        sel_arvalid = m_arvalid[i];
        sel_rready  = m_rready[i];
      end
    end
  end

  // Winner of the next arbitration round.
  logic [1:0] pick;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    if (m_arvalid[1])      pick = 2'd1;
    else if (m_arvalid[2]) pick = 2'd2;
    else                   pick = 2'd0;
  end
`else
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Scan from the farthest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    pick = rr_ptr_q;
    for (int k = 2; k >= 0; k--) begin
      if (m_arvalid[rr_idx(rr_ptr_q, 2'(k))]) pick = rr_idx(rr_ptr_q, 2'(k));
    end
  end
`endif

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    m_arready  = 3'b000;
    m_rvalid   = 3'b000;
    m_rlast    = 1'b0;
    arvalid    = 1'b0;
    araddr     = '0;
    arlen      = '0;
    arsize     = '0;
    rready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|m_arvalid) begin
          gnt_d   = pick;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        araddr    = sel_addr;
        arlen     = sel_len;
        arsize    = sel_size;
        arvalid   = sel_arvalid;
        m_arready = {2'b00, arready} << gnt_q;
        if (sel_arvalid && arready) begin
          len_d      = sel_len;
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        m_rvalid = {2'b00, rvalid} << gnt_q;
        m_rlast  = rlast;
        rready   = sel_rready;
        if (rvalid && sel_rready) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (rlast) begin
            // A short or long burst is flagged but still terminated on rlast.
            if (beat_cnt_q != len_q) len_err_d = 1'b1;
            state_d = ST_IDLE;
`ifdef ARB_FIXED_PRIO_EN
            rr_ptr_d = 2'd0;
`else
            rr_ptr_d = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
`endif
          end else if (beat_cnt_q == len_q) begin
            len_err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= 4'd0;
      len_q      <= 4'd0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed self-checking bench for axi_rd_rr_arbiter (default build; fixed-priority
// expectations selected by ARB_FIXED_PRIO_EN).
module tb_axi_rd_rr_arbiter;

  localparam int         ADDR_W  = 32;
  localparam int         DATA_W  = 32;
  localparam logic [3:0] ID_BASE = 4'd0;
  localparam int         ST_IDLE = 0, ST_ADDR = 1, ST_DATA = 2;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [3*ADDR_W-1:0] m_araddr = '0;
  logic [11:0]         m_arlen = '0;
  logic [8:0]          m_arsize = '0;
  logic [2:0]          m_arvalid = '0;
  logic [2:0]          m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rlast;
  logic [2:0]          m_rvalid;
  logic [2:0]          m_rready = '0;
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready = 1'b0;
  logic [3:0]          rid = '0;
  logic [DATA_W-1:0]   rdata = '0;
  logic [1:0]          rresp = '0;
  logic                rlast = 1'b0;
  logic                rvalid = 1'b0;
  logic                rready;
  logic                len_err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_BASE(ID_BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later still.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Outer-slave beat: present one beat and advance a cycle.
  task automatic beat(input logic [31:0] d, input logic last);
    rvalid = 1'b1;
    rdata  = d;
    rlast  = last;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  int exp_order[4];
  int n_grants;
  bit drop_after_grant;

  initial begin
    // ---------------- reset state ----------------
    aresetn = 1'b0;
    tick();
    settle();
    check("rst_m_arready", m_arready, 3'b000);
    check("rst_m_rvalid",  m_rvalid,  3'b000);
    check("rst_arvalid",   arvalid,   1'b0);
    check("rst_rready",    rready,    1'b0);
    check("rst_arid",      arid,      ID_BASE);
    check("rst_arburst",   arburst,   2'b01);
    check("rst_arlock",    arlock,    2'b00);
    check("rst_arcache",   arcache,   4'b0000);
    check("rst_arprot",    arprot,    3'b000);
    check("rst_len_err",   len_err,   1'b0);
    check("rst_state",     dut.state_q, ST_IDLE);
    tick();
    aresetn = 1'b1;

    // ---------------- single m0 8-beat burst ----------------
    m_araddr[0 +: 32] = 32'hBFC0_0000;
    m_arlen[0 +: 4]   = 4'd7;
    m_arsize[0 +: 3]  = 3'd2;
    m_arvalid         = 3'b001;
    m_rready          = 3'b111;
    settle();
    check("m0_idle_no_ar", arvalid, 1'b0);
    tick();
    settle();
    check("m0_arvalid", arvalid, 1'b1);
    check("m0_araddr",  araddr,  32'hBFC0_0000);
    check("m0_arlen",   arlen,   4'd7);
    check("m0_arsize",  arsize,  3'd2);
    check("m0_arid",    arid,    ID_BASE);
    arready = 1'b1;
    settle();
    check("m0_m_arready", m_arready, 3'b001);
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    for (int b = 0; b < 8; b++) begin
      rvalid = 1'b1;
      rdata  = 32'hA000_0000 + b;
      rlast  = (b == 7);
      settle();
      check("m0_rvalid", m_rvalid, 3'b001);
      check("m0_rdata",  m_rdata,  32'hA000_0000 + b);
      check("m0_rlast",  m_rlast,  (b == 7));
      check("m0_rready", rready,   1'b1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    settle();
    check("m0_done_state",   dut.state_q, ST_IDLE);
    check("m0_done_len_err", len_err,     1'b0);

    // ---------------- grant order with all masters requesting ----------------
    do_reset();
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{1, 2, 0, 0};
    n_grants  = 3;
    drop_after_grant = 1'b1;
`else
    exp_order = '{0, 1, 2, 0};
    n_grants  = 4;
    drop_after_grant = 1'b0;
`endif
    m_arlen   = '0;
    m_arvalid = 3'b111;
    for (int n = 0; n < n_grants; n++) begin
      int waited;
      waited = 0;
      settle();
      while (!arvalid && waited < 8) begin
        tick();
        settle();
        waited++;
      end
      check("gnt_arvalid", arvalid, 1'b1);
      check("gnt_order",   arid,    ID_BASE + 4'(exp_order[n]));
      arready = 1'b1;
      settle();
      check("gnt_m_arready", m_arready, 3'b001 << exp_order[n]);
      tick();
      arready = 1'b0;
      if (drop_after_grant) m_arvalid[exp_order[n]] = 1'b0;
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = 32'(n);
      settle();
      check("gnt_m_rvalid", m_rvalid, 3'b001 << exp_order[n]);
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    m_arvalid = 3'b000;
    tick();

    // ---------------- AR stall: arready low for 5 cycles ----------------
    m_araddr[64 +: 32] = 32'h1234_5678;
    m_arlen[8 +: 4]    = 4'd0;
    m_arvalid          = 3'b100;
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      check("stall_arvalid",   arvalid,     1'b1);
      check("stall_araddr",    araddr,      32'h1234_5678);
      check("stall_m_arready", m_arready,   3'b000);
      check("stall_state",     dut.state_q, ST_ADDR);
      tick();
    end
    check("stall_arid", arid, ID_BASE + 4'd2);
    arready = 1'b1;
    settle();
    check("stall_release", m_arready, 3'b100);
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    beat(32'h0, 1'b1);

    // ---------------- m_rready back-pressure mid-burst ----------------
    m_arlen[4 +: 4] = 4'd3;
    m_arvalid       = 3'b010;
    tick();
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    beat(32'hB0, 1'b0);
    m_rready = 3'b101;
    rvalid   = 1'b1;
    rdata    = 32'hB1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp_rready",   rready,         1'b0);
      check("bp_m_rvalid", m_rvalid,       3'b010);
      check("bp_beat_cnt", dut.beat_cnt_q, 4'd1);
      tick();
    end
    m_rready = 3'b111;
    settle();
    check("bp_rdata", m_rdata, 32'hB1);
    tick();
    check("bp_beat_cnt_adv", dut.beat_cnt_q, 4'd2);
    beat(32'hB2, 1'b0);
    beat(32'hB3, 1'b1);
    settle();
    check("bp_state",   dut.state_q, ST_IDLE);
    check("bp_len_err", len_err,     1'b0);

    // ---------------- early rlast: 3 beats on a 4-beat burst ----------------
    m_arlen[0 +: 4] = 4'd3;
    m_arvalid       = 3'b001;
    tick();
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    beat(32'hC0, 1'b0);
    beat(32'hC1, 1'b0);
    beat(32'hC2, 1'b1);
    settle();
    check("short_len_err", len_err,     1'b1);
    check("short_state",   dut.state_q, ST_IDLE);
    m_arlen[4 +: 4] = 4'd0;
    m_arvalid       = 3'b010;
    tick();
    settle();
    check("short_next_arvalid", arvalid, 1'b1);
    check("short_next_arid",    arid,    ID_BASE + 4'd1);
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    beat(32'hD0, 1'b1);
    settle();
    check("short_next_idle",   dut.state_q, ST_IDLE);
    check("short_err_sticky",  len_err,     1'b1);

    // ---------------- async reset mid-DATA ----------------
    m_arlen[8 +: 4] = 4'd7;
    m_arvalid       = 3'b100;
    tick();
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    m_arvalid = 3'b000;
    beat(32'hE0, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'hE1;
    settle();
    check("pre_rst_m_rvalid", m_rvalid, 3'b100);
    aresetn = 1'b0;
    settle();
    check("mid_rst_m_rvalid", m_rvalid,     3'b000);
    check("mid_rst_rready",   rready,       1'b0);
    check("mid_rst_arvalid",  arvalid,      1'b0);
    check("mid_rst_state",    dut.state_q,  ST_IDLE);
    check("mid_rst_rr_ptr",   dut.rr_ptr_q, 2'd0);
    check("mid_rst_len_err",  len_err,      1'b0);
    check("mid_rst_arid",     arid,         ID_BASE);
    rvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
